// File: rtl/crc_link_arq_controller_if.sv
// Upstream frame and downstream result handshakes of the CRC link ARQ controller.
// master: requester/consumer side; slave: controller side.
interface crc_link_arq_controller_if #(
  parameter int unsigned WIDTH = 15
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_status;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_status
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_status
  );
endinterface

// File: rtl/crc_link_arq_controller.sv
// Stop-and-wait ARQ sequencer around the CRC/parity transmitter and receiver datapaths.
// Optional first-attempt error injection is enabled by defining CRC_ARQ_ERR_INJECT_EN.
module crc_link_arq_controller #(
  parameter int unsigned WIDTH       = 15,
  parameter int unsigned CALC_CYCLES = 20,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  crc_link_arq_controller_if.slave link,
  output logic                     tx_rst,
  output logic [WIDTH-1:0]         tx_data,
  input  logic [WIDTH-1:0]         tx_code,
  output logic                     rx_rst,
  output logic [WIDTH-1:0]         rx_data,
  input  logic [WIDTH-1:0]         rx_out,
  input  logic                     rx_error,
  output logic [2:0]               retry_cnt
`ifdef CRC_ARQ_ERR_INJECT_EN
  ,
  input  logic [WIDTH-1:0]         inject_mask,
  output logic                     inject_active
`endif
);

  typedef enum logic [2:0] {
    IDLE, TX_LOAD, TX_WAIT, RX_LOAD, RX_WAIT, CHECK, RESP
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(CALC_CYCLES - 1);
  localparam logic [2:0] MAX_R    = 3'(MAX_RETRY);

  state_t           state, state_nxt;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] frame_reg;
  logic [WIDTH-1:0] code_reg;
  logic [WIDTH-1:0] mask_reg;
  logic             accept, tx_done, retry;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    link.in_ready  = 1'b0;
    link.out_valid = 1'b0;
    tx_rst         = 1'b1;
    rx_rst         = 1'b1;
    accept         = 1'b0;
    tx_done        = 1'b0;
    retry          = 1'b0;
    unique case (state)
      IDLE: begin
        link.in_ready = !reset;
        if (link.in_valid && !reset) begin
          accept    = 1'b1;
          state_nxt = TX_LOAD;
        end
      end
      TX_LOAD: state_nxt = TX_WAIT;
      TX_WAIT: begin
        tx_rst = 1'b0;
        if (cnt == '0) begin
          tx_done   = 1'b1;
          state_nxt = RX_LOAD;
        end
      end
      RX_LOAD: state_nxt = RX_WAIT;
      RX_WAIT: begin
        rx_rst = 1'b0;
        if (cnt == '0) state_nxt = CHECK;
      end
      CHECK: begin
        if (rx_error && (retry_cnt < MAX_R)) begin
          retry     = 1'b1;
          state_nxt = TX_LOAD;
        end else begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        link.out_valid = 1'b1;
        if (link.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_reg       <= '0;
      code_reg        <= '0;
      mask_reg        <= '0;
      cnt             <= '0;
      retry_cnt       <= '0;
      link.out_data   <= '0;
      link.out_status <= '0;
    end else begin
      if (accept) begin
        frame_reg <= link.in_data;
        retry_cnt <= '0;
`ifdef CRC_ARQ_ERR_INJECT_EN
        mask_reg  <= inject_mask;
`else
        mask_reg  <= '0;
`endif
      end
      if (state == TX_LOAD || state == RX_LOAD)
        cnt <= CNT_INIT;
      else if ((state == TX_WAIT || state == RX_WAIT) && cnt != '0)
        cnt <= cnt - 8'd1;
      if (tx_done) code_reg <= tx_code;
      if (retry) retry_cnt <= retry_cnt + 3'd1;
      if (state == CHECK && !retry) begin
        link.out_data   <= rx_out;
        link.out_status <= rx_error ? 2'b10 : ((retry_cnt == '0) ? 2'b00 : 2'b01);
      end
    end
  end

  // frame_reg doubles as the transmitter input; it only changes on accept.
  assign tx_data = frame_reg;
  // Injection applies only while no retry has been spent on this frame.
  assign rx_data = code_reg ^ ((retry_cnt == '0) ? mask_reg : '0);

`ifdef CRC_ARQ_ERR_INJECT_EN
  assign inject_active = (state == RX_LOAD || state == RX_WAIT) && (retry_cnt == '0) && (mask_reg != '0);
`endif

endmodule

// File: tb/tb_crc_link_arq_controller.sv
// Self-checking bench for crc_link_arq_controller: bench-side datapath models plus
// a per-frame outcome model (attempts, status, latency) derived from the ARQ rules.
module tb_crc_link_arq_controller;
  localparam int unsigned WIDTH = 15;
  localparam int unsigned CALC  = 20;
  localparam int unsigned MAXR  = 3;
  localparam logic [14:0] KEY   = 15'h2D5B;
  localparam int LAT0 = 2 * CALC + 4;
  localparam int LATR = 2 * CALC + 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_rst, rx_rst, rx_error;
  logic [14:0] tx_data, tx_code, rx_data, rx_out;
  logic [2:0]  retry_cnt;
`ifdef CRC_ARQ_ERR_INJECT_EN
  logic [14:0] inject_mask = '0;
  logic        inject_active;
`endif

  int vectors = 0;
  int miscompares = 0;
  int attempt = 0;
  int err_k = 0;
  logic [14:0] rx_q;
  logic        err_q;

  crc_link_arq_controller_if #(.WIDTH(WIDTH)) link ();

  crc_link_arq_controller #(.WIDTH(WIDTH), .CALC_CYCLES(CALC), .MAX_RETRY(MAXR)) dut (
    .clk       (clk),
    .reset     (reset),
    .link      (link),
    .tx_rst    (tx_rst),
    .tx_data   (tx_data),
    .tx_code   (tx_code),
    .rx_rst    (rx_rst),
    .rx_data   (rx_data),
    .rx_out    (rx_out),
    .rx_error  (rx_error),
    .retry_cnt (retry_cnt)
`ifdef CRC_ARQ_ERR_INJECT_EN
    ,
    .inject_mask   (inject_mask),
    .inject_active (inject_active)
`endif
  );

  always #5 clk = ~clk;

  // Transmitter model: encodes while out of reset. Receiver model: registered,
  // synchronously cleared by rx_rst, flags scheduled errors or a corrupted codeword.
  assign tx_code = tx_rst ? '0 : (tx_data ^ KEY);
  always @(posedge clk) begin
    if (rx_rst) begin
      rx_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rx_q  <= rx_data ^ KEY;
      err_q <= (attempt < err_k) || (rx_data != (tx_data ^ KEY));
    end
  end
  assign rx_out   = rx_q;
  assign rx_error = err_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [14:0] frame, input int k, input int hold, input logic [14:0] mask);
    int   cyc, windows, lead, exp_retry, exp_lat, guard;
    logic [1:0] exp_st;
    logic prev_tx, busy_ready, seen;
`ifdef CRC_ARQ_ERR_INJECT_EN
    logic rx_checked;
    rx_checked = 1'b0;
`endif
    guard = 0;
    while (!link.in_ready && guard < 100) begin
      step();
      guard++;
    end
    chk("in_ready_idle", 32'(link.in_ready), 32'd1);

    lead      = (k == 0 && mask != '0) ? 1 : k;
    exp_retry = (lead > int'(MAXR)) ? int'(MAXR) : lead;
    exp_st    = (lead == 0) ? 2'b00 : ((lead <= int'(MAXR)) ? 2'b01 : 2'b10);
    exp_lat   = LAT0 + exp_retry * LATR;

    err_k   = k;
    attempt = 0;
`ifdef CRC_ARQ_ERR_INJECT_EN
    inject_mask = mask;
`endif
    link.in_data   = frame;
    link.in_valid  = 1'b1;
    link.out_ready = (hold == 0);
    cyc = 0; windows = 0; prev_tx = 1'b1; busy_ready = 1'b0; seen = 1'b0;
    while (!seen && cyc < exp_lat + 50) begin
      step();
      cyc++;
      link.in_valid = 1'b0;
      link.in_data  = 15'($urandom);
      if (prev_tx && !tx_rst) begin
        windows++;
        attempt = windows - 1;
      end
      prev_tx = tx_rst;
      if (link.in_ready) busy_ready = 1'b1;
`ifdef CRC_ARQ_ERR_INJECT_EN
      if (!rx_rst && windows == 1 && !rx_checked) begin
        chk("inject_rx_data", 32'(rx_data), 32'((frame ^ KEY) ^ mask));
        chk("inject_active", 32'(inject_active), 32'(mask != '0));
        rx_checked = 1'b1;
      end
`endif
      seen = link.out_valid;
    end
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("tx_windows", 32'(windows), 32'(exp_retry + 1));
    chk("in_ready_busy", 32'(busy_ready), 32'd0);
    chk("out_status", 32'(link.out_status), 32'(exp_st));
    chk("retry_cnt", 32'(retry_cnt), 32'(exp_retry));
    chk("out_data", 32'(link.out_data), 32'(frame));
    chk("tx_data_hold", 32'(tx_data), 32'(frame));

    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 32'(link.out_valid), 32'd1);
      chk("hold_data", 32'(link.out_data), 32'(frame));
      chk("hold_in_ready", 32'(link.in_ready), 32'd0);
    end
    link.out_ready = 1'b1;
    step();
    chk("post_hs_valid", 32'(link.out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(link.in_ready), 32'd1);
    link.out_ready = 1'b0;
  endtask

  initial begin
    int   windows, guard;
    logic prev_tx, spurious;
    logic [14:0] f;

    link.in_valid  = 1'b0;
    link.in_data   = '0;
    link.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", 32'(link.in_ready), 32'd0);
    chk("rst_out_valid", 32'(link.out_valid), 32'd0);
    chk("rst_tx_rst", 32'(tx_rst), 32'd1);
    chk("rst_rx_rst", 32'(rx_rst), 32'd1);
    chk("rst_retry_cnt", 32'(retry_cnt), 32'd0);
    chk("rst_out_data", 32'(link.out_data), 32'd0);
    chk("rst_out_status", 32'(link.out_status), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(link.in_ready), 32'd1);

    run_frame(15'b111010011010000, 0, 0, '0);
    run_frame(15'b111010011010000, 1, 0, '0);
    run_frame(15'($urandom), 15, 0, '0);
    run_frame(15'($urandom), 0, 10, '0);

    // Abort in the second attempt's RX_WAIT, where retry_cnt is nonzero.
    err_k = 2;
    attempt = 0;
    link.in_data  = 15'($urandom);
    link.in_valid = 1'b1;
    windows = 0; prev_tx = 1'b1; guard = 0;
    while (!(windows == 2 && !rx_rst) && guard < 400) begin
      step();
      guard++;
      link.in_valid = 1'b0;
      if (prev_tx && !tx_rst) begin
        windows++;
        attempt = windows - 1;
      end
      prev_tx = tx_rst;
    end
    chk("abort_reached_rx_wait", 32'(windows == 2 && !rx_rst), 32'd1);
    chk("abort_retry_before", 32'(retry_cnt), 32'd1);
    reset = 1'b1;
    step();
    chk("abort_tx_rst", 32'(tx_rst), 32'd1);
    chk("abort_rx_rst", 32'(rx_rst), 32'd1);
    chk("abort_out_valid", 32'(link.out_valid), 32'd0);
    chk("abort_retry_cnt", 32'(retry_cnt), 32'd0);
    chk("abort_in_ready_in_rst", 32'(link.in_ready), 32'd0);
    reset = 1'b0;
    step();
    chk("abort_in_ready_after", 32'(link.in_ready), 32'd1);
    spurious = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (link.out_valid || !tx_rst) spurious = 1'b1;
    end
    chk("abort_no_output", 32'(spurious), 32'd0);

`ifdef CRC_ARQ_ERR_INJECT_EN
    run_frame(15'b111010011010000, 0, 0, 15'b000000000001100);
`endif

    for (int n = 0; n < 12; n++) begin
      f = 15'($urandom);
      run_frame(f, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
